// File: rtl/mcycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH -> DECODE -> EXECUTE -> [MEM] -> [WB].
// Build option DMEM_HANDSHAKE_EN: MEM holds d_req until d_ack is sampled high.
module mcycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_code,
    input  logic        b_taken,
    input  logic        d_ack,
    output logic        ir_en,
    output logic        pc_en,
    output logic        reg_wr_en,
    output logic        aluSrcMuxSel,
    output logic        branch,
    output logic        jal,
    output logic        jalr,
    output logic [2:0]  RegWdataSel,
    output logic [3:0]  alu_controls,
    output logic        d_req,
    output logic        d_we,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [31:0] instret
);
    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4
    } state_e;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    state_e      state_q, state_d;
    logic [31:0] instret_q, instret_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5;
    assign opcode = instr_code[6:0];
    assign funct3 = instr_code[14:12];
    assign f7b5   = instr_code[30];

    logic is_r, is_i, is_ld, is_st, is_br, is_lui, is_auipc, is_jal, is_jalr;
    logic is_legal, writes_rd;
    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_I);
    assign is_ld     = (opcode == OP_LD);
    assign is_st     = (opcode == OP_ST);
    assign is_br     = (opcode == OP_BR);
    assign is_lui    = (opcode == OP_LUI);
    assign is_auipc  = (opcode == OP_AUIPC);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_legal  = is_r | is_i | is_ld | is_st | is_br | is_lui | is_auipc | is_jal | is_jalr;
    assign writes_rd = is_r | is_i | is_ld | is_lui | is_auipc | is_jal | is_jalr;

    logic mem_done;
    logic unused_in;
`ifdef DMEM_HANDSHAKE_EN
    assign mem_done  = d_ack;
    assign unused_in = ^{b_taken, instr_code[31], instr_code[29:15], instr_code[11:7]};
`else
    assign mem_done  = 1'b1;
    assign unused_in = ^{d_ack, b_taken, instr_code[31], instr_code[29:15], instr_code[11:7]};
`endif

    // Per-opcode datapath controls; only driven out once the IR is valid (post-FETCH).
    logic       c_asrc;
    logic [2:0] c_wsel;
    logic [3:0] c_alu;
    always_comb begin
        c_asrc = 1'b0;
        c_wsel = 3'd0;
        c_alu  = 4'd0;
        case (opcode)
            OP_R:     c_alu = {f7b5, funct3};
            OP_I: begin
                c_asrc = 1'b1;
                c_alu  = (funct3 == 3'b101) ? {f7b5, funct3} : {1'b0, funct3};
            end
            OP_LD: begin
                c_asrc = 1'b1;
                c_wsel = 3'd1;
            end
            OP_ST:    c_asrc = 1'b1;
            OP_BR:    c_alu  = {1'b0, funct3};
            OP_LUI:   c_wsel = 3'd2;
            OP_AUIPC: c_wsel = 3'd3;
            OP_JAL:   c_wsel = 3'd4;
            OP_JALR: begin
                c_asrc = 1'b1;
                c_wsel = 3'd4;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    logic fin;
    // Outputs are gated by reset directly so they drop in the same cycle reset asserts.
    always_comb begin
        state_d      = state_q;
        instret_d    = instret_q;
        fin          = 1'b0;
        ir_en        = 1'b0;
        pc_en        = 1'b0;
        reg_wr_en    = 1'b0;
        aluSrcMuxSel = 1'b0;
        branch       = 1'b0;
        jal          = 1'b0;
        jalr         = 1'b0;
        RegWdataSel  = 3'd0;
        alu_controls = 4'd0;
        d_req        = 1'b0;
        d_we         = 1'b0;
        illegal      = 1'b0;
        if (reset) begin
            if (state_q != S_FETCH && is_legal) begin
                aluSrcMuxSel = c_asrc;
                branch       = is_br;
                jal          = is_jal | is_jalr;
                jalr         = is_jalr;
                RegWdataSel  = c_wsel;
                alu_controls = c_alu;
            end
            case (state_q)
                S_FETCH: begin
                    ir_en   = 1'b1;
                    state_d = S_DECODE;
                end
                S_DECODE: begin
                    if (!is_legal) begin
                        illegal = 1'b1;
                        pc_en   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (is_r || is_i) begin
                        state_d = S_WB;
                    end else if (is_ld || is_st) begin
                        state_d = S_MEM;
                    end else begin
                        fin     = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_MEM: begin
                    d_req = 1'b1;
                    d_we  = is_st;
                    if (mem_done) begin
                        if (is_st) begin
                            fin     = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                end
                S_WB: begin
                    fin     = 1'b1;
                    state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
            if (fin) begin
                pc_en     = 1'b1;
                reg_wr_en = writes_rd;
                instret_d = instret_q + 32'd1;
            end
        end
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule
